// File: rtl/ppu_pkg.sv
// ppu_pkg: shared scroll-register types, timing constants and CPU register indices
package ppu_pkg;

  typedef struct packed {
    logic [2:0] fine_y;
    logic [1:0] nt;
    logic [4:0] coarse_y;
    logic [4:0] coarse_x;
  } vram_addr_t;

  localparam logic [8:0] DOT_YINC           = 9'd255;
  localparam logic [8:0] DOT_HCOPY          = 9'd256;
  localparam logic [8:0] DOT_VCOPY_FIRST    = 9'd279;
  localparam logic [8:0] DOT_VCOPY_LAST     = 9'd303;
  localparam logic [8:0] DOT_PREFETCH_FIRST = 9'd320;
  localparam logic [8:0] DOT_PREFETCH_LAST  = 9'd335;
  localparam logic [8:0] SCANLINE_PRERENDER = 9'd261;

  typedef enum logic [2:0] {
    REG_CTRL    = 3'd0,
    REG_MASK    = 3'd1,
    REG_STATUS  = 3'd2,
    REG_OAMADDR = 3'd3,
    REG_OAMDATA = 3'd4,
    REG_SCROLL  = 3'd5,
    REG_ADDR    = 3'd6,
    REG_DATA    = 3'd7
  } ppu_reg_e;

endpackage

// File: rtl/ppu_scroll_incr.sv
// ppu_scroll_incr: combinational coarse-X and Y increment of the v register
module ppu_scroll_incr
  import ppu_pkg::*;
(
  input  vram_addr_t v_i,
  input  logic       inc_x_i,
  input  logic       inc_y_i,
  output vram_addr_t v_o
);

  logic y_wrap;

  assign y_wrap = v_i.fine_y == 3'd7;

  // coarse X wraps 31->0 into the next horizontal nametable; Y rolls fine_y into coarse_y
  always_comb begin
    v_o = v_i;
    if (inc_x_i) begin
      v_o.coarse_x = v_i.coarse_x + 5'd1;
      v_o.nt[0]    = v_i.nt[0] ^ (v_i.coarse_x == 5'd31);
    end
    if (inc_y_i) begin
      v_o.fine_y   = y_wrap ? 3'd0 : v_i.fine_y + 3'd1;
      v_o.coarse_y = !y_wrap ? v_i.coarse_y :
                     (v_i.coarse_y == 5'd29 || v_i.coarse_y == 5'd31) ? 5'd0 : v_i.coarse_y + 5'd1;
      v_o.nt[1]    = v_i.nt[1] ^ (y_wrap && v_i.coarse_y == 5'd29);
    end
  end

endmodule

// File: rtl/ppu_scroll_ctrl.sv
// ppu_scroll_ctrl: PPU loopy v/t/fine_x/w scroll registers; PPU_RENDER_2007_GLITCH_EN enables the $2007 increment glitch during rendering
module ppu_scroll_ctrl
  import ppu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [8:0]  dot_i,
  input  logic [8:0]  scanline_i,
  input  logic        rendering_en_i,
  input  logic        reg_wr_i,
  input  logic        reg_rd_i,
  input  logic [2:0]  reg_addr_i,
  input  logic [7:0]  reg_data_i,
  output logic [14:0] vram_addr_o,
  output logic [2:0]  fine_x_o,
  output logic        write_toggle_o,
  output logic        inc32_o
);

  vram_addr_t v_q, v_d, t_q, t_d, v_inc, v_r;
  logic [2:0] fx_q, fx_d;
  logic       w_q, w_d, inc32_q, inc32_d, load_v;
  logic       render, x_dot, h_copy, v_copy, reg7, glitch, inc_x, inc_y;

  assign render = rendering_en_i && (scanline_i <= 9'd239 || scanline_i == SCANLINE_PRERENDER);
  assign x_dot  = dot_i[2:0] == 3'd7 &&
                  (dot_i <= DOT_YINC || (dot_i >= DOT_PREFETCH_FIRST && dot_i <= DOT_PREFETCH_LAST));
  assign h_copy = render && dot_i == DOT_HCOPY;
  assign v_copy = rendering_en_i && scanline_i == SCANLINE_PRERENDER &&
                  dot_i >= DOT_VCOPY_FIRST && dot_i <= DOT_VCOPY_LAST;
  assign reg7   = (reg_wr_i || reg_rd_i) && reg_addr_i == REG_DATA;
`ifdef PPU_RENDER_2007_GLITCH_EN
  assign glitch = reg7;
`else
  assign glitch = 1'b0;
`endif
  assign inc_x  = render && (x_dot || glitch);
  assign inc_y  = render && (dot_i == DOT_YINC || glitch);

  ppu_scroll_incr u_incr (
    .v_i     (v_q),
    .inc_x_i (inc_x),
    .inc_y_i (inc_y),
    .v_o     (v_inc)
  );

  // CPU register writes into t/fine_x/w, then pick the next v by priority: $2006 load, render, $2007 step
  always_comb begin
    t_d     = t_q;
    fx_d    = fx_q;
    w_d     = w_q;
    inc32_d = inc32_q;
    load_v  = 1'b0;
    if (reg_wr_i && reg_addr_i == REG_CTRL) begin
      t_d.nt  = reg_data_i[1:0];
      inc32_d = reg_data_i[2];
    end
    if (reg_wr_i && reg_addr_i == REG_SCROLL) begin
      if (!w_q) begin
        t_d.coarse_x = reg_data_i[7:3];
        fx_d         = reg_data_i[2:0];
      end else begin
        t_d.fine_y   = reg_data_i[2:0];
        t_d.coarse_y = reg_data_i[7:3];
      end
      w_d = ~w_q;
    end
    if (reg_wr_i && reg_addr_i == REG_ADDR) begin
      if (!w_q) t_d[14:8] = {1'b0, reg_data_i[5:0]};
      else begin
        t_d[7:0] = reg_data_i;
        load_v   = 1'b1;
      end
      w_d = ~w_q;
    end
    if (reg_rd_i && reg_addr_i == REG_STATUS) w_d = 1'b0;
    v_r = v_inc;
    if (h_copy) begin
      v_r.nt[0]    = t_q.nt[0];
      v_r.coarse_x = t_q.coarse_x;
    end
    if (v_copy) begin
      v_r.fine_y   = t_q.fine_y;
      v_r.nt[1]    = t_q.nt[1];
      v_r.coarse_y = t_q.coarse_y;
    end
    v_d = load_v ? t_d :
          render ? v_r :
          reg7   ? vram_addr_t'(v_q + (inc32_q ? 15'd32 : 15'd1)) : v_q;
  end

  // scroll state registers with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q     <= '0;
      t_q     <= '0;
      fx_q    <= '0;
      w_q     <= 1'b0;
      inc32_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      t_q     <= t_d;
      fx_q    <= fx_d;
      w_q     <= w_d;
      inc32_q <= inc32_d;
    end
  end

  assign vram_addr_o    = v_q;
  assign fine_x_o       = fx_q;
  assign write_toggle_o = w_q;
  assign inc32_o        = inc32_q;

endmodule

// File: tb/tb_ppu_scroll_ctrl.sv
// tb_ppu_scroll_ctrl: directed self-checking bench for ppu_scroll_ctrl
module tb_ppu_scroll_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  dot = 9'd340;
  logic [8:0]  scanline = 9'd240;
  logic        ren = 1'b0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [2:0]  reg_addr = 3'd0;
  logic [7:0]  reg_data = 8'd0;
  logic [14:0] vram_addr;
  logic [2:0]  fine_x;
  logic        wtog;
  logic        inc32;
  int          checks = 0;
  int          failures = 0;

  ppu_scroll_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .dot_i          (dot),
    .scanline_i     (scanline),
    .rendering_en_i (ren),
    .reg_wr_i       (reg_wr),
    .reg_rd_i       (reg_rd),
    .reg_addr_i     (reg_addr),
    .reg_data_i     (reg_data),
    .vram_addr_o    (vram_addr),
    .fine_x_o       (fine_x),
    .write_toggle_o (wtog),
    .inc32_o        (inc32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_wr = 1'b1;
    reg_addr = a;
    reg_data = d;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    @(negedge clk);
    reg_rd = 1'b1;
    reg_addr = a;
    @(negedge clk);
    reg_rd = 1'b0;
  endtask

  task automatic step(input logic [8:0] sl, input logic [8:0] d, input logic en);
    @(negedge clk);
    scanline = sl;
    dot = d;
    ren = en;
    @(negedge clk);
    scanline = 9'd240;
    dot = 9'd340;
    ren = 1'b0;
  endtask

  task automatic copy_t;
    step(9'd261, 9'd256, 1'b1);
    step(9'd261, 9'd279, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_v", 16'(vram_addr), 16'h0000);
    check("rst_fx", 16'(fine_x), 16'h0);
    check("rst_w", 16'(wtog), 16'h0);
    check("rst_inc32", 16'(inc32), 16'h0);
    rst_n = 1'b1;

    wr(3'd6, 8'h21);
    check("r6_first_w", 16'(wtog), 16'h1);
    check("r6_first_v_hold", 16'(vram_addr), 16'h0000);
    wr(3'd6, 8'h08);
    check("r6_second_v", 16'(vram_addr), 16'h2108);
    check("r6_second_w", 16'(wtog), 16'h0);
    wr(3'd0, 8'h04);
    check("r0_inc32", 16'(inc32), 16'h1);
    wr(3'd7, 8'h00);
    check("r7_wr_inc32", 16'(vram_addr), 16'h2128);
    rd(3'd7);
    check("r7_rd_inc32", 16'(vram_addr), 16'h2148);
    wr(3'd0, 8'h00);
    rd(3'd7);
    check("r7_rd_inc1", 16'(vram_addr), 16'h2149);

    wr(3'd5, 8'h7D);
    wr(3'd5, 8'h5E);
    check("r5_fine_x", 16'(fine_x), 16'h5);
    check("r5_w", 16'(wtog), 16'h0);
    copy_t();
    check("r5_t_via_copy", 16'(vram_addr), 16'h616F);

    wr(3'd6, 8'h00);
    wr(3'd6, 8'h1F);
    check("cx31_setup", 16'(vram_addr), 16'h001F);
    step(9'd10, 9'd7, 1'b1);
    check("cx_wrap", 16'(vram_addr), 16'h0400);
    step(9'd10, 9'd8, 1'b1);
    check("cx_hold_dot8", 16'(vram_addr), 16'h0400);
    step(9'd10, 9'd327, 1'b1);
    check("cx_prefetch", 16'(vram_addr), 16'h0401);

    wr(3'd5, 8'h00);
    wr(3'd5, 8'hEF);
    copy_t();
    check("y29_setup", 16'(vram_addr), 16'h73A0);
    step(9'd10, 9'd255, 1'b1);
    check("y29_wrap", 16'(vram_addr), 16'h0801);
    wr(3'd5, 8'h00);
    wr(3'd5, 8'hFF);
    copy_t();
    check("y31_setup", 16'(vram_addr), 16'h73E0);
    step(9'd10, 9'd255, 1'b1);
    check("y31_wrap", 16'(vram_addr), 16'h0001);
    step(9'd10, 9'd255, 1'b1);
    check("y_fine_inc", 16'(vram_addr), 16'h1002);
    step(9'd245, 9'd255, 1'b1);
    check("vblank_hold", 16'(vram_addr), 16'h1002);
    step(9'd10, 9'd7, 1'b0);
    check("render_off_hold", 16'(vram_addr), 16'h1002);

    wr(3'd0, 8'h02);
    wr(3'd5, 8'hF8);
    wr(3'd5, 8'hFF);
    step(9'd261, 9'd256, 1'b1);
    check("hcopy", 16'(vram_addr), 16'h101F);
    for (int d = 279; d <= 303; d++) step(9'd261, 9'(d), 1'b1);
    check("vcopy", 16'(vram_addr), 16'h7BFF);

    wr(3'd6, 8'h00);
    @(negedge clk);
    reg_wr = 1'b1;
    reg_addr = 3'd6;
    reg_data = 8'h05;
    scanline = 9'd10;
    dot = 9'd7;
    ren = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
    ren = 1'b0;
    dot = 9'd340;
    scanline = 9'd240;
    check("r6_priority_v", 16'(vram_addr), 16'h0005);
    check("r6_priority_w", 16'(wtog), 16'h0);

    @(negedge clk);
    reg_wr = 1'b1;
    reg_addr = 3'd7;
    scanline = 9'd10;
    dot = 9'd100;
    ren = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
    ren = 1'b0;
    dot = 9'd340;
    scanline = 9'd240;
`ifdef PPU_RENDER_2007_GLITCH_EN
    check("r7_render", 16'(vram_addr), 16'h1006);
`else
    check("r7_render", 16'(vram_addr), 16'h0005);
`endif

    wr(3'd5, 8'h7D);
    check("r2_pre_w", 16'(wtog), 16'h1);
    rd(3'd2);
    check("r2_clear_w", 16'(wtog), 16'h0);
    rd(3'd1);
    check("r1_no_effect", 16'(wtog), 16'h0);
    wr(3'd0, 8'h04);
    wr(3'd5, 8'h7D);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_v", 16'(vram_addr), 16'h0000);
    check("arst_fx", 16'(fine_x), 16'h0);
    check("arst_w", 16'(wtog), 16'h0);
    check("arst_inc32", 16'(inc32), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(9'd10, 9'd7, 1'b1);
    check("post_rst_resume", 16'(vram_addr), 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
